// File: rtl/simd_pkg.sv
// Shared definitions for the 4-lane SIMD frame accumulator: lane geometry and FSM states.
package simd_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/simd_lane_acc_cell.sv
// One lane's frame accumulator register; load/add/clear strobes come from the shared FSM
// and are already qualified with the clock enable.
module simd_lane_acc_cell
    import simd_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_add,
    input  logic              i_clear,
    input  logic [LANE_W-1:0] i_z,
    output logic [AW-1:0]     o_acc
);

    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_z_ext;

    assign w_z_ext = {{(AW-LANE_W){1'b0}}, i_z};

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_z_ext;
        end else if (i_add) begin
            r_acc <= r_acc + w_z_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/simd_lane_accum.sv
// Accumulates LEN four-lane beats into per-lane frame totals, holds each result until
// accepted, and flags beats dropped while a result is pending.
module simd_lane_accum
    import simd_pkg::*;
#(
    parameter int LEN = 8,
    parameter int AW  = 10 + $clog2(LEN)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_ce,
    input  logic [LANE_W-1:0] z1,
    input  logic [LANE_W-1:0] z2,
    input  logic [LANE_W-1:0] z3,
    input  logic [LANE_W-1:0] z4,
    input  logic              z_ap_vld,
    output logic [AW-1:0]     acc1,
    output logic [AW-1:0]     acc2,
    output logic [AW-1:0]     acc3,
    output logic [AW-1:0]     acc4,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              overrun,
    output logic              ap_idle
);

    localparam int CW = $clog2(LEN + 1);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_acc_valid;
    logic          r_idle;
    logic          r_overrun;

    logic          w_beat;
    logic          w_hs;
    logic          w_last;
    logic          w_load;
    logic          w_add;
    logic          w_clear;

    logic [LANE_W-1:0] w_z   [LANES];
    logic [AW-1:0]     w_acc [LANES];

    assign w_beat = ap_ce & z_ap_vld;
    assign w_hs   = ap_ce & r_acc_valid & acc_ready;
    assign w_last = (r_count == CW'(LEN - 1));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_load  = 1'b0;
        w_add   = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            IDLE:  w_load = w_beat;
            ACCUM: w_add  = w_beat;
            HOLD: begin
                if (w_hs) begin
                    w_load  = w_beat;
                    w_clear = ~w_beat;
                end
            end
            default: ;
        endcase
    end

    // NOTE: reset is synchronous and deliberately outranks ap_ce, so a frozen block still resets.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_acc_valid <= 1'b0;
            r_idle      <= 1'b1;
            r_overrun   <= 1'b0;
        end else if (ap_ce) begin
            case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        r_state <= ACCUM;
                        r_count <= CW'(1);
                        r_idle  <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        r_count <= r_count + CW'(1);
                        if (w_last) begin
                            r_state     <= HOLD;
                            r_acc_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_hs && w_beat) begin
                        // Back-to-back frame: the beat riding on the handshake opens the next frame.
                        r_state     <= ACCUM;
                        r_count     <= CW'(1);
                        r_acc_valid <= 1'b0;
                    end else if (w_hs) begin
                        r_state     <= IDLE;
                        r_count     <= '0;
                        r_acc_valid <= 1'b0;
                        r_idle      <= 1'b1;
                    end else if (w_beat) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_count     <= '0;
                    r_acc_valid <= 1'b0;
                    r_idle      <= 1'b1;
                end
            endcase
        end
    end

    assign w_z[0] = z1;
    assign w_z[1] = z2;
    assign w_z[2] = z3;
    assign w_z[3] = z4;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        simd_lane_acc_cell #(.AW(AW)) u_cell (
            .clk     (ap_clk),
            .rst     (ap_rst),
            .i_load  (w_load),
            .i_add   (w_add),
            .i_clear (w_clear),
            .i_z     (w_z[g]),
            .o_acc   (w_acc[g])
        );
    end

    assign acc1      = w_acc[0];
    assign acc2      = w_acc[1];
    assign acc3      = w_acc[2];
    assign acc4      = w_acc[3];
    assign acc_valid = r_acc_valid;
    assign ap_idle   = r_idle;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_simd_lane_accum.sv
// Directed bench for simd_lane_accum (LEN=8): full-scale frame, gapped beats, overrun and
// back-to-back handshake, clock-enable freeze, and mid-frame reset.
module tb_simd_lane_accum;

    localparam int LEN = 8;
    localparam int AW  = 10 + $clog2(LEN);

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          ap_ce;
    logic [9:0]    z1, z2, z3, z4;
    logic          z_ap_vld;
    logic [AW-1:0] acc1, acc2, acc3, acc4;
    logic          acc_valid;
    logic          acc_ready;
    logic          overrun;
    logic          ap_idle;

    int errors = 0;
    int checks = 0;

    simd_lane_accum #(.LEN(LEN)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_ce     (ap_ce),
        .z1        (z1),
        .z2        (z2),
        .z3        (z3),
        .z4        (z4),
        .z_ap_vld  (z_ap_vld),
        .acc1      (acc1),
        .acc2      (acc2),
        .acc3      (acc3),
        .acc4      (acc4),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .overrun   (overrun),
        .ap_idle   (ap_idle)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_acc(input string tag, input int e1, input int e2, input int e3, input int e4);
        check({tag, ".acc1"}, 32'(acc1), 32'(e1));
        check({tag, ".acc2"}, 32'(acc2), 32'(e2));
        check({tag, ".acc3"}, 32'(acc3), 32'(e3));
        check({tag, ".acc4"}, 32'(acc4), 32'(e4));
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic beat(input int a, input int b, input int c, input int d);
        z1 = 10'(a); z2 = 10'(b); z3 = 10'(c); z4 = 10'(d);
        z_ap_vld = 1'b1;
        step();
        z_ap_vld = 1'b0;
    endtask

    initial begin
        ap_rst = 1'b1; ap_ce = 1'b1; z_ap_vld = 1'b0; acc_ready = 1'b0;
        z1 = '0; z2 = '0; z3 = '0; z4 = '0;
        idle_cycles(2);
        ap_rst = 1'b0;
        check_acc("reset", 0, 0, 0, 0);
        check("reset.acc_valid", 32'(acc_valid), 32'd0);
        check("reset.overrun", 32'(overrun), 32'd0);
        check("reset.ap_idle", 32'(ap_idle), 32'd1);

        // Full-scale frame, consecutive beats.
        for (int i = 0; i < LEN; i++) begin
            beat(1, 2, 1023, 0);
            check("full.ap_idle", 32'(ap_idle), 32'd0);
            if (i < LEN - 1) check("full.early_valid", 32'(acc_valid), 32'd0);
        end
        check("full.acc_valid", 32'(acc_valid), 32'd1);
        check_acc("full", 8, 16, 8184, 0);
        idle_cycles(2);
        check_acc("full.stable", 8, 16, 8184, 0);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        check("hs.ap_idle", 32'(ap_idle), 32'd1);
        check("hs.acc_valid", 32'(acc_valid), 32'd0);
        check_acc("hs.cleared", 0, 0, 0, 0);

        // Gapped beats: 0..3 idle cycles between beats.
        for (int i = 0; i < LEN; i++) begin
            if (i < LEN - 1) check("gap.early_valid", 32'(acc_valid), 32'd0);
            beat(5, 5, 5, 5);
            idle_cycles(i % 4);
        end
        check("gap.acc_valid", 32'(acc_valid), 32'd1);
        check_acc("gap", 40, 40, 40, 40);

        // Pending result, beat arrives without handshake: dropped, overrun sticky.
        step();
        beat(7, 7, 7, 7);
        step();
        check("ovr.overrun", 32'(overrun), 32'd1);
        check("ovr.acc_valid", 32'(acc_valid), 32'd1);
        check_acc("ovr.unchanged", 40, 40, 40, 40);

        // Handshake plus simultaneous beat opens the next frame.
        acc_ready = 1'b1;
        beat(9, 0, 0, 0);
        acc_ready = 1'b0;
        check_acc("b2b", 9, 0, 0, 0);
        check("b2b.acc_valid", 32'(acc_valid), 32'd0);
        check("b2b.ap_idle", 32'(ap_idle), 32'd0);
        for (int i = 1; i < LEN; i++) beat(1, 1, 1, 1);
        check("b2b.done_valid", 32'(acc_valid), 32'd1);
        check_acc("b2b.total", 16, 7, 7, 7);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        check("b2b.back_idle", 32'(ap_idle), 32'd1);

        // Clock-enable freeze after beat 3 with valid and ready held high.
        for (int i = 0; i < 3; i++) beat(2, 3, 4, 5);
        check_acc("ce.pre", 6, 9, 12, 15);
        ap_ce = 1'b0; acc_ready = 1'b1;
        z1 = 10'd100; z2 = 10'd100; z3 = 10'd100; z4 = 10'd100;
        z_ap_vld = 1'b1;
        idle_cycles(4);
        z_ap_vld = 1'b0;
        check_acc("ce.frozen", 6, 9, 12, 15);
        check("ce.acc_valid", 32'(acc_valid), 32'd0);
        check("ce.ap_idle", 32'(ap_idle), 32'd0);
        ap_ce = 1'b1; acc_ready = 1'b0;
        for (int i = 3; i < LEN; i++) beat(2, 3, 4, 5);
        check("ce.acc_valid_done", 32'(acc_valid), 32'd1);
        check_acc("ce.total", 16, 24, 32, 40);
        check("ce.overrun_sticky", 32'(overrun), 32'd1);
        ap_ce = 1'b0; acc_ready = 1'b1;
        idle_cycles(2);
        check("ce.hold_no_hs", 32'(acc_valid), 32'd1);
        ap_ce = 1'b1;
        step();
        acc_ready = 1'b0;
        check("ce.hs_idle", 32'(ap_idle), 32'd1);

        // Reset mid-frame (with ap_ce low) discards the partial frame and the overrun flag.
        for (int i = 0; i < 5; i++) beat(3, 3, 3, 3);
        check_acc("rst.partial", 15, 15, 15, 15);
        ap_rst = 1'b1; ap_ce = 1'b0;
        step();
        ap_rst = 1'b0; ap_ce = 1'b1;
        check_acc("rst", 0, 0, 0, 0);
        check("rst.acc_valid", 32'(acc_valid), 32'd0);
        check("rst.overrun", 32'(overrun), 32'd0);
        check("rst.ap_idle", 32'(ap_idle), 32'd1);
        for (int i = 0; i < LEN; i++) beat(1, 1, 1, 1);
        check("rst.new_valid", 32'(acc_valid), 32'd1);
        check_acc("rst.new", 8, 8, 8, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_lane_accum.md
SIMD_LANE_ACCUM -- requirements
Module: simd_lane_accum

Interface
REQ-001 SHALL have parameter LEN, default 8, meaning input beats per frame; legal range 2..64.
REQ-002 SHALL have parameter AW, default 10+clog2(LEN), meaning accumulator width; derived, not overridden.
REQ-003 SHALL have port ap_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port ap_rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port ap_ce, input, 1, clock enable; all state frozen while low.
REQ-006 SHALL have ports z1, z2, z3, z4, input, 10 each, unsigned lane sums from the upstream 4-lane SIMD adder.
REQ-007 SHALL have port z_ap_vld, input, 1, beat valid; the upstream per-lane valids are tied together, so one beat carries all four lanes.
REQ-008 SHALL have ports acc1, acc2, acc3, acc4, output, AW each, per-lane frame totals.
REQ-009 SHALL have port acc_valid, output, 1, frame result available.
REQ-010 SHALL have port acc_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port overrun, output, 1, sticky flag for dropped beats.
REQ-012 SHALL have port ap_idle, output, 1, high when no frame is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-014 An accepted beat is z_ap_vld=1 with ap_ce=1; the block SHALL ignore inputs on all other cycles.
REQ-015 In IDLE, an accepted beat SHALL load acc_n=z_n zero-extended, set beat count=1 and move to ACCUM.
REQ-016 In ACCUM, an accepted beat SHALL add z_n to acc_n and increment the count.
REQ-017 When the LEN-th beat is accepted, the block SHALL move to HOLD and assert acc_valid on the next cycle; latency is 1 cycle after the last beat.
REQ-018 In HOLD, acc1..acc4 and acc_valid SHALL stay stable until a handshake, i.e. acc_valid=1, acc_ready=1 and ap_ce=1.
REQ-019 On a handshake with no beat in the same cycle, the block SHALL return to IDLE with accumulators cleared.
REQ-020 On a handshake with a beat in the same cycle, the block SHALL start a new frame with that beat (acc=z, count=1, ACCUM) and SHALL NOT drop it.
REQ-021 An accepted beat in HOLD without a handshake SHALL be dropped and SHALL set overrun, which stays at 1 until reset.
REQ-022 Arithmetic SHALL be unsigned with no saturation; AW guarantees no wrap (LEN=8: max 8184 < 8192).
REQ-023 ap_idle SHALL equal (state==IDLE); acc_valid SHALL equal (state==HOLD).
REQ-024 Gaps between beats SHALL be allowed in any state; the count advances only on accepted beats.

Reset
REQ-025 When ap_rst=1 at a clock edge, the block SHALL set state=IDLE, count=0, acc1..acc4=0, acc_valid=0, overrun=0 and ap_idle=1, regardless of ap_ce.
REQ-026 Reset mid-frame or in HOLD SHALL discard the partial or pending frame; the first beat after reset starts a fresh frame.

Structure
REQ-027 Shared package simd_pkg SHALL hold LANES=4, LANE_W=10 and the FSM state enum.
REQ-028 SHALL instantiate sub-module simd_lane_acc_cell four times; each holds one lane's AW-bit register with load/add/clear controls from the common FSM.
REQ-029 The FSM and beat counter (clog2(LEN+1) bits) SHALL be single instances shared by all four lanes.

Verification
REQ-030 LEN=8, 8 consecutive beats z=(1,2,1023,0) -> acc=(8,16,8184,0); acc_valid rises 1 cycle after the 8th beat; ap_idle=0 throughout.
REQ-031 8 beats of z=(5,5,5,5) separated by 0-3 idle cycles -> acc=(40,40,40,40); no early acc_valid.
REQ-032 HOLD with acc_ready=0 for 3 cycles and a beat z=(7,7,7,7) arriving -> overrun=1, acc unchanged; then acc_ready=1 with a simultaneous beat z=(9,0,0,0) -> next frame begins with acc=(9,0,0,0), state=ACCUM.
REQ-033 ap_ce=0 for 4 cycles after beat 3 while z_ap_vld=1 and acc_ready=1 -> no count/acc change and no handshake; the final total counts only accepted beats.
REQ-034 ap_rst=1 after beat 5 -> next cycle all outputs 0, ap_idle=1; 8 new beats of z=(1,1,1,1) -> acc=(8,8,8,8).
